wm_control_panel: RTL and testbench
===================================

# wm_control_panel

Front-panel input stage directly upstream of the washing machine controller. Synchronises and debounces raw push-buttons and option switches, latches the wash program at launch, issues the single-cycle `start` request, owns the `time_pause` toggle, and tracks cycle completion from the controller's `done`. All controller inputs (`start`, `double_wash`, `dry_wash`, `time_pause`) are driven from registers in this block.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops per raw input, ≥2.
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples required to change a debounced level, ≥1.
- `CNT_W`, 5: debounce counter width; must hold `DEBOUNCE_CYCLES`.

Ports:
- `clk`  in  1  single clock, shared with the controller.
- `rst`  in  1  synchronous, active-high reset.
- `btn_start`  in  1  raw start button, asynchronous, high = pressed.
- `btn_pause`  in  1  raw pause button, asynchronous, high = pressed.
- `sw_double`  in  1  raw double-wash switch, asynchronous.
- `sw_dry`  in  1  raw dry-wash switch, asynchronous.
- `done`  in  1  controller completion flag.
- `start`  out  1  one-cycle launch request to controller.
- `double_wash`  out  1  latched program option.
- `dry_wash`  out  1  latched program option.
- `time_pause`  out  1  pause level to controller.
- `run_led`  out  1  high in LAUNCH and RUN.
- `done_led`  out  1  high in COMPLETE.

## Operation
- Every raw input passes through an identical conditioning channel: `SYNC_STAGES`-flop synchroniser, then debouncer. Debounced level changes only after the synchronised value differs from it for `DEBOUNCE_CYCLES` consecutive cycles; any mismatch-free sample resets the counter.
- Press pulse = debounced level rising (level & ~level_prev), one cycle wide, for `btn_start` and `btn_pause` only.
- FSM states: IDLE, LAUNCH, RUN, COMPLETE.
  - IDLE: start press → LAUNCH; latch debounced `sw_double`/`sw_dry` into `double_wash`/`dry_wash` on the same edge.
  - LAUNCH (exactly one cycle): `start`=1; → RUN.
  - RUN: `start`=0. Pause press toggles `time_pause`. Rising edge of `done` (`done` & ~`done_prev`) → COMPLETE, clearing `time_pause` on the same edge.
  - COMPLETE: start press → LAUNCH with options re-latched.
- Options held constant from LAUNCH until the next launch; switch changes during RUN/COMPLETE are ignored.
- Boundary rules:
  - Start press in LAUNCH/RUN: ignored.
  - Pause press outside RUN: ignored; `time_pause` is 0 outside RUN.
  - Start and pause presses in the same cycle in IDLE/COMPLETE: start wins, pause discarded.
  - Pause press in the same cycle as `done` rising in RUN: transition wins, `time_pause` = 0.
  - `done` high or rising in IDLE, LAUNCH, COMPLETE: ignored (stale `done` from a previous cycle cannot complete a new one; an edge is required).
  - Reset mid-operation: state IDLE, all outputs 0, synchronisers, debounce counters, debounced levels and `done_prev` cleared. A button held through reset deasserts then produces a press after normal debounce latency.

## Timing
- Reset values: `start`, `double_wash`, `dry_wash`, `time_pause`, `run_led`, `done_led` all 0.
- All outputs registered; no combinational path from any input to any output.
- Raw button rising before edge 0 and held: synchronised at edge `SYNC_STAGES`-1, debounced level and press pulse high after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`-1, state LAUNCH and `start`=1 for the following cycle. Defaults: `start` high 18 cycles after first sampling.
- Pulses shorter than `DEBOUNCE_CYCLES` synchronised cycles never register.
- `done` rising sampled at edge n → COMPLETE and `done_led`=1 at edge n (visible cycle n+1).

## Structure
- Shared package `wm_pkg`: panel state enum (IDLE/LAUNCH/RUN/COMPLETE), default `SYNC_STAGES`/`DEBOUNCE_CYCLES` constants; controller state encodings already there.
- Sub-module `wm_debounce` (sync chain + counter + level + rise pulse), instantiated four times; pulse output unused for switches.

## Test plan
- Reset with all buttons low, release → all outputs 0 for 100 cycles; hold `btn_start` 10 cycles then release → no `start` (below debounce).
- `sw_double`=1, `sw_dry`=0, hold `btn_start` 40 cycles → exactly one `start` cycle 18 cycles after press, `double_wash`=1, `dry_wash`=0, `run_led`=1; toggle `sw_double` in RUN → `double_wash` stays 1.
- In RUN, two debounced pause presses 50 cycles apart → `time_pause` 1 then 0; pause press in IDLE → `time_pause` stays 0.
- In RUN with `time_pause`=1, raise `done` → COMPLETE, `time_pause`=0, `done_led`=1; hold `done` high and press start → one `start`, RUN, no early COMPLETE until `done` falls and rises again.
- Start and pause presses aligned to same debounced edge in COMPLETE → launch, `time_pause`=0.
- Assert `rst` one cycle mid-RUN with `btn_start` held → outputs 0 next cycle, then new `start` 18 cycles after reset release.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared definitions for the washing machine front panel and controller.
package wm_pkg;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_CNT_W           = 5;

   typedef enum logic [1:0] {
      PANEL_IDLE     = 2'd0,
      PANEL_LAUNCH   = 2'd1,
      PANEL_RUN      = 2'd2,
      PANEL_COMPLETE = 2'd3
   } panel_state_t;

   typedef enum logic [2:0] {
      CTRL_IDLE  = 3'd0,
      CTRL_FILL  = 3'd1,
      CTRL_WASH  = 3'd2,
      CTRL_RINSE = 3'd3,
      CTRL_SPIN  = 3'd4,
      CTRL_DRY   = 3'd5
   } ctrl_state_t;

endpackage

// File: rtl/wm_control_panel_debounce.sv
// One conditioning channel: synchroniser chain, stability counter, debounced
// level and a one-cycle rising-edge pulse.
module wm_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   level_prev_q;
   logic                   synced;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], din};
      synced  = sync_q[SYNC_STAGES-1];
      level_d = level_q;
      cnt_d   = '0;
      // any sample agreeing with the current level restarts the count
      if (synced != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = synced;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q       <= '0;
         cnt_q        <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
      end
   end

   assign level = level_q;
   assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/wm_control_panel.sv
// Front-panel input stage: conditions buttons/switches, sequences launch,
// owns the pause toggle and tracks completion from the controller.
//
//   state    | meaning
//   IDLE     | waiting for first start press
//   LAUNCH   | one-cycle start request, options latched
//   RUN      | controller running; pause toggles, done edge completes
//   COMPLETE | cycle finished; start press relaunches
module wm_control_panel
   import wm_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_start,
   input  logic btn_pause,
   input  logic sw_double,
   input  logic sw_dry,
   input  logic done,
   output logic start,
   output logic double_wash,
   output logic dry_wash,
   output logic time_pause,
   output logic run_led,
   output logic done_led
);

   logic start_lvl_unused, pause_lvl_unused;
   logic dbl_rise_unused, dry_rise_unused;
   logic start_press, pause_press, dbl_lvl, dry_lvl;

   wm_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
      u_db_start  (.clk(clk), .rst(rst), .din(btn_start), .level(start_lvl_unused), .rise(start_press));
   wm_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
      u_db_pause  (.clk(clk), .rst(rst), .din(btn_pause), .level(pause_lvl_unused), .rise(pause_press));
   wm_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
      u_db_double (.clk(clk), .rst(rst), .din(sw_double), .level(dbl_lvl), .rise(dbl_rise_unused));
   wm_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
      u_db_dry    (.clk(clk), .rst(rst), .din(sw_dry), .level(dry_lvl), .rise(dry_rise_unused));

   panel_state_t state_q, state_d;
   logic start_q, start_d;
   logic double_q, double_d;
   logic dry_q, dry_d;
   logic pause_q, pause_d;
   logic run_led_q, run_led_d;
   logic done_led_q, done_led_d;
   logic done_prev_q;
   logic done_rise;

   assign done_rise = done & ~done_prev_q;

   always_comb begin
      state_d  = state_q;
      double_d = double_q;
      dry_d    = dry_q;
      pause_d  = pause_q;
      case (state_q)
         PANEL_IDLE, PANEL_COMPLETE: begin
            pause_d = 1'b0;
            if (start_press) begin
               state_d  = PANEL_LAUNCH;
               double_d = dbl_lvl;
               dry_d    = dry_lvl;
            end
         end
         PANEL_LAUNCH: begin
            pause_d = 1'b0;
            state_d = PANEL_RUN;
         end
         PANEL_RUN: begin
            // completion outranks a simultaneous pause press
            if (done_rise) begin
               state_d = PANEL_COMPLETE;
               pause_d = 1'b0;
            end else if (pause_press) begin
               pause_d = ~pause_q;
            end
         end
         default: state_d = PANEL_IDLE;
      endcase
      start_d    = (state_d == PANEL_LAUNCH);
      run_led_d  = (state_d == PANEL_LAUNCH) || (state_d == PANEL_RUN);
      done_led_d = (state_d == PANEL_COMPLETE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PANEL_IDLE;
         start_q     <= 1'b0;
         double_q    <= 1'b0;
         dry_q       <= 1'b0;
         pause_q     <= 1'b0;
         run_led_q   <= 1'b0;
         done_led_q  <= 1'b0;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         double_q    <= double_d;
         dry_q       <= dry_d;
         pause_q     <= pause_d;
         run_led_q   <= run_led_d;
         done_led_q  <= done_led_d;
         done_prev_q <= done;
      end
   end

   assign start       = start_q;
   assign double_wash = double_q;
   assign dry_wash    = dry_q;
   assign time_pause  = pause_q;
   assign run_led     = run_led_q;
   assign done_led    = done_led_q;

endmodule

// File: tb/tb_wm_control_panel.sv
// Directed bench for the washing machine front panel with hand-computed timing.
module tb_wm_control_panel;

   logic clk = 1'b0;
   logic rst, btn_start, btn_pause, sw_double, sw_dry, done;
   logic start, double_wash, dry_wash, time_pause, run_led, done_led;
   int checks = 0;
   int errors = 0;

   wm_control_panel dut (
      .clk(clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
      .sw_double(sw_double), .sw_dry(sw_dry), .done(done), .start(start),
      .double_wash(double_wash), .dry_wash(dry_wash), .time_pause(time_pause),
      .run_led(run_led), .done_led(done_led)
   );

   always #5 clk = ~clk;

   // inputs change 1 time unit after a rising edge; outputs are read there too
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      int bad, starts;
      rst = 1; btn_start = 0; btn_pause = 0; sw_double = 0; sw_dry = 0; done = 0;
      tick(3);
      checks++;
      if ({start, double_wash, dry_wash, time_pause, run_led, done_led} !== 6'b0) begin
         errors++; $display("FAIL reset_outputs got=%b want=000000",
            {start, double_wash, dry_wash, time_pause, run_led, done_led});
      end
      rst = 0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if ({start, double_wash, dry_wash, time_pause, run_led, done_led} !== 6'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL idle_quiet nonzero_cycles=%0d want=0", bad); end
      btn_start = 1;
      starts = 0;
      for (int i = 0; i < 10; i++) begin tick(1); if (start === 1'b1) starts++; end
      btn_start = 0;
      for (int i = 0; i < 40; i++) begin tick(1); if (start === 1'b1) starts++; end
      checks++;
      if (starts !== 0) begin errors++; $display("FAIL short_press starts=%0d want=0", starts); end
   endtask

   task automatic test_pause_idle;
      int bad;
      bad = 0;
      btn_pause = 1;
      for (int i = 0; i < 30; i++) begin tick(1); if (time_pause !== 1'b0) bad++; end
      btn_pause = 0;
      for (int i = 0; i < 25; i++) begin tick(1); if (time_pause !== 1'b0) bad++; end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL pause_in_idle bad_cycles=%0d want=0", bad); end
   endtask

   task automatic test_launch;
      int starts, first;
      sw_double = 1; sw_dry = 0;
      tick(30);
      btn_start = 1;
      starts = 0; first = -1;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         if (start === 1'b1) begin starts++; if (first < 0) first = k; end
      end
      checks++;
      if (starts !== 1) begin errors++; $display("FAIL launch_count starts=%0d want=1", starts); end
      checks++;
      if (first !== 19) begin errors++; $display("FAIL launch_latency edge=%0d want=19", first); end
      checks++;
      if ({double_wash, dry_wash, run_led, done_led} !== 4'b1010) begin
         errors++; $display("FAIL launch_opts got=%b want=1010", {double_wash, dry_wash, run_led, done_led});
      end
      btn_start = 0;
      sw_double = 0; sw_dry = 1;
      tick(30);
      checks++;
      if ({double_wash, dry_wash, run_led} !== 3'b101) begin
         errors++; $display("FAIL opts_held_in_run got=%b want=101", {double_wash, dry_wash, run_led});
      end
   endtask

   task automatic test_pause_toggle;
      btn_pause = 1; tick(25);
      checks++;
      if (time_pause !== 1'b1) begin errors++; $display("FAIL pause_first got=%b want=1", time_pause); end
      btn_pause = 0; tick(25);
      btn_pause = 1; tick(25);
      checks++;
      if (time_pause !== 1'b0) begin errors++; $display("FAIL pause_second got=%b want=0", time_pause); end
      btn_pause = 0; tick(25);
   endtask

   task automatic test_done_complete;
      int starts, early;
      btn_pause = 1; tick(25); btn_pause = 0; tick(25);
      checks++;
      if (time_pause !== 1'b1) begin errors++; $display("FAIL pause_before_done got=%b want=1", time_pause); end
      done = 1; tick(1);
      checks++;
      if ({done_led, run_led, time_pause} !== 3'b100) begin
         errors++; $display("FAIL done_complete got=%b want=100", {done_led, run_led, time_pause});
      end
      btn_start = 1;
      starts = 0; early = 0;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         if (start === 1'b1) starts++;
         if (k > 19 && done_led !== 1'b0) early++;
      end
      btn_start = 0;
      checks++;
      if (starts !== 1) begin errors++; $display("FAIL relaunch_count starts=%0d want=1", starts); end
      checks++;
      if (early !== 0 || run_led !== 1'b1) begin
         errors++; $display("FAIL stale_done early=%0d run_led=%b want 0/1", early, run_led);
      end
      checks++;
      if ({double_wash, dry_wash} !== 2'b01) begin
         errors++; $display("FAIL relatch_opts got=%b want=01", {double_wash, dry_wash});
      end
      tick(25);
      done = 0; tick(1);
      done = 1; tick(1);
      checks++;
      if ({done_led, run_led} !== 2'b10) begin
         errors++; $display("FAIL second_done got=%b want=10", {done_led, run_led});
      end
   endtask

   task automatic test_same_edge;
      int starts, bad;
      btn_start = 1; btn_pause = 1;
      starts = 0; bad = 0;
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         if (start === 1'b1) starts++;
         if (time_pause !== 1'b0) bad++;
      end
      btn_start = 0; btn_pause = 0;
      tick(25);
      checks++;
      if (starts !== 1 || bad !== 0 || run_led !== 1'b1) begin
         errors++; $display("FAIL same_edge starts=%0d pause_cycles=%0d run_led=%b want 1/0/1",
            starts, bad, run_led);
      end
   endtask

   task automatic test_pause_with_done;
      done = 0;
      btn_pause = 1;
      tick(18);
      done = 1;
      tick(1);
      checks++;
      if ({done_led, time_pause} !== 2'b10) begin
         errors++; $display("FAIL pause_vs_done got=%b want=10", {done_led, time_pause});
      end
      btn_pause = 0;
      tick(25);
   endtask

   task automatic test_reset_mid;
      int starts, first;
      btn_start = 1;
      tick(25);
      checks++;
      if ({run_led, dry_wash} !== 2'b11) begin
         errors++; $display("FAIL pre_reset_run got=%b want=11", {run_led, dry_wash});
      end
      rst = 1; tick(1);
      checks++;
      if ({start, double_wash, dry_wash, time_pause, run_led, done_led} !== 6'b0) begin
         errors++; $display("FAIL mid_reset_outputs got=%b want=000000",
            {start, double_wash, dry_wash, time_pause, run_led, done_led});
      end
      rst = 0;
      starts = 0; first = -1;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         if (start === 1'b1) begin starts++; if (first < 0) first = k; end
      end
      checks++;
      if (starts !== 1 || first !== 19) begin
         errors++; $display("FAIL post_reset_launch starts=%0d edge=%0d want 1/19", starts, first);
      end
      btn_start = 0;
   endtask

   initial begin
      test_reset();
      test_pause_idle();
      test_launch();
      test_pause_toggle();
      test_done_complete();
      test_same_edge();
      test_pause_with_done();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
